fault_supervisor: RTL and testbench

//  Qualifies raw fault inputs (motor-driver overcurrent flags, battery A2D reading) and produces filtered

---
 rtl/fault_pkg.sv | 24 ++
 rtl/ovr_chan_filt.sv | 99 +++++++++
 rtl/fault_supervisor.sv | 93 +++++++++
 tb/tb_fault_supervisor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fault_pkg.sv
// Shared types and default thresholds for the fault supervisor.
// FAULT_STICKY_EN (ovr_chan_filt) makes overcurrent shutdown latch until pwr_up drops.
package fault_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    SHTDWN  = 2'd1,
    RECOVER = 2'd2
  } ovr_state_t;

  typedef struct packed {
    logic ovr;
    logic batt;
  } fault_code_t;

  localparam int unsigned BATT_W            = 12;
  localparam logic [11:0] BATT_LOW_THR_DEF  = 12'h800;
  localparam logic [11:0] BATT_HYST_DEF     = 12'h040;
  localparam int unsigned BATT_FILT_DEF     = 4;
  localparam int unsigned OVR_BLANK_DEF     = 256;
  localparam int unsigned OVR_LIMIT_DEF     = 16;
  localparam int unsigned RECOV_PERIODS_DEF = 8;

endpackage

// File: rtl/ovr_chan_filt.sv
// One overcurrent channel: synchronizer, post-edge blanking, faulted-period counting and shutdown FSM.
// FAULT_STICKY_EN: SHTDWN never auto-recovers; only pwr_up low returns the channel to NORMAL.
module ovr_chan_filt
  import fault_pkg::*;
#(
  parameter int unsigned OVR_BLANK     = OVR_BLANK_DEF,
  parameter int unsigned OVR_LIMIT     = OVR_LIMIT_DEF,
  parameter int unsigned RECOV_PERIODS = RECOV_PERIODS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_synch,
  input  logic ovr_i,
  input  logic pwr_up,
  output logic shtdwn_c
);

  localparam int unsigned BLANK_W = $clog2(OVR_BLANK + 1);
  localparam int unsigned CNT_W   = $clog2(OVR_LIMIT + 1);
  localparam int unsigned CLEAN_W = $clog2(RECOV_PERIODS + 1);

  logic [1:0]         sync_q, sync_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic               faulted_q, faulted_d;
  ovr_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CLEAN_W-1:0] clean_cnt_q, clean_cnt_d;
  logic               period_faulted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      blank_cnt_q <= '0;
      faulted_q   <= 1'b0;
      state_q     <= NORMAL;
      cnt_q       <= '0;
      clean_cnt_q <= '0;
    end else begin
      sync_q      <= sync_d;
      blank_cnt_q <= blank_cnt_d;
      faulted_q   <= faulted_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clean_cnt_q <= clean_cnt_d;
    end
  end

  always_comb begin
    sync_d         = {sync_q[0], ovr_i};
    // A hit on the pwm_synch clk still belongs to the period being closed.
    period_faulted = faulted_q | (sync_q[1] && (blank_cnt_q == BLANK_W'(OVR_BLANK)));
    blank_cnt_d    = blank_cnt_q;
    faulted_d      = period_faulted;
    state_d        = state_q;
    cnt_d          = cnt_q;
    clean_cnt_d    = clean_cnt_q;

    if (blank_cnt_q != BLANK_W'(OVR_BLANK)) blank_cnt_d = blank_cnt_q + BLANK_W'(1);
    if (pwm_synch) begin
      blank_cnt_d = '0;
      faulted_d   = 1'b0;
    end

    if (!pwr_up) begin
      state_d     = NORMAL;
      cnt_d       = '0;
      clean_cnt_d = '0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (pwm_synch) begin
            if (period_faulted)      cnt_d = cnt_q + CNT_W'(1);
            else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
            if (cnt_d == CNT_W'(OVR_LIMIT)) state_d = SHTDWN;
          end
        end
        SHTDWN: begin
`ifdef FAULT_STICKY_EN
          state_d = SHTDWN;
`else
          if (pwm_synch) begin
            clean_cnt_d = period_faulted ? '0 : clean_cnt_q + CLEAN_W'(1);
            if (clean_cnt_d == CLEAN_W'(RECOV_PERIODS)) state_d = RECOVER;
          end
`endif
        end
        RECOVER: begin
          state_d     = NORMAL;
          cnt_d       = '0;
          clean_cnt_d = '0;
        end
        default: state_d = NORMAL;
      endcase
    end

    shtdwn_c = (state_d == SHTDWN);
  end

endmodule

// File: rtl/fault_supervisor.sv
// Qualifies overcurrent and battery faults into registered shutdown, low-battery and alarm status.
// FAULT_STICKY_EN selects latching overcurrent shutdown (see ovr_chan_filt).
module fault_supervisor
  import fault_pkg::*;
#(
  parameter logic [11:0] BATT_LOW_THR  = BATT_LOW_THR_DEF,
  parameter logic [11:0] BATT_HYST     = BATT_HYST_DEF,
  parameter int unsigned BATT_FILT     = BATT_FILT_DEF,
  parameter int unsigned OVR_BLANK     = OVR_BLANK_DEF,
  parameter int unsigned OVR_LIMIT     = OVR_LIMIT_DEF,
  parameter int unsigned RECOV_PERIODS = RECOV_PERIODS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_synch,
  input  logic              OVR_I_lft,
  input  logic              OVR_I_rght,
  input  logic [BATT_W-1:0] batt,
  input  logic              batt_vld,
  input  logic              pwr_up,
  output logic              ovr_i_shtdwn,
  output logic              batt_low,
  output logic              alarm_req,
  output logic [1:0]        fault_code
);

  localparam int unsigned LOW_W = $clog2(BATT_FILT + 1);

  logic             shtdwn_lft_c, shtdwn_rght_c;
  logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
  logic             batt_low_q, batt_low_d;
  logic             ovr_i_shtdwn_q, ovr_i_shtdwn_d;
  logic             alarm_req_q, alarm_req_d;
  fault_code_t      fault_code_q, fault_code_d;
  logic             batt_is_low, batt_is_clear;

  ovr_chan_filt #(
    .OVR_BLANK(OVR_BLANK), .OVR_LIMIT(OVR_LIMIT), .RECOV_PERIODS(RECOV_PERIODS)
  ) u_lft (
    .clk(clk), .rst(rst), .pwm_synch(pwm_synch), .ovr_i(OVR_I_lft), .pwr_up(pwr_up),
    .shtdwn_c(shtdwn_lft_c)
  );

  ovr_chan_filt #(
    .OVR_BLANK(OVR_BLANK), .OVR_LIMIT(OVR_LIMIT), .RECOV_PERIODS(RECOV_PERIODS)
  ) u_rght (
    .clk(clk), .rst(rst), .pwm_synch(pwm_synch), .ovr_i(OVR_I_rght), .pwr_up(pwr_up),
    .shtdwn_c(shtdwn_rght_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_cnt_q      <= '0;
      batt_low_q     <= 1'b0;
      ovr_i_shtdwn_q <= 1'b0;
      alarm_req_q    <= 1'b0;
      fault_code_q   <= '0;
    end else begin
      low_cnt_q      <= low_cnt_d;
      batt_low_q     <= batt_low_d;
      ovr_i_shtdwn_q <= ovr_i_shtdwn_d;
      alarm_req_q    <= alarm_req_d;
      fault_code_q   <= fault_code_d;
    end
  end

  always_comb begin
    batt_is_low   = (batt < BATT_LOW_THR);
    // Hysteresis sum formed in 13 bits so a large threshold cannot wrap.
    batt_is_clear = ({1'b0, batt} >= (13'(BATT_LOW_THR) + 13'(BATT_HYST)));
    low_cnt_d     = low_cnt_q;
    batt_low_d    = batt_low_q;

    if (batt_vld) begin
      if (!batt_is_low)                        low_cnt_d = '0;
      else if (low_cnt_q != LOW_W'(BATT_FILT)) low_cnt_d = low_cnt_q + LOW_W'(1);
    end

    if (batt_vld && batt_is_clear)           batt_low_d = 1'b0;
    else if (low_cnt_q == LOW_W'(BATT_FILT)) batt_low_d = 1'b1;

    ovr_i_shtdwn_d    = shtdwn_lft_c | shtdwn_rght_c;
    alarm_req_d       = ovr_i_shtdwn_d | batt_low_d;
    fault_code_d.ovr  = ovr_i_shtdwn_d;
    fault_code_d.batt = batt_low_d;
  end

  assign ovr_i_shtdwn = ovr_i_shtdwn_q;
  assign batt_low     = batt_low_q;
  assign alarm_req    = alarm_req_q;
  assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_fault_supervisor.sv
// Directed bench for fault_supervisor; observed vector is {ovr_i_shtdwn, batt_low, alarm_req, fault_code}.
module tb_fault_supervisor;

  localparam int P = 300;

  logic        clk = 1'b0;
  logic        rst, pwm_synch, OVR_I_lft, OVR_I_rght, batt_vld, pwr_up;
  logic [11:0] batt;
  logic        ovr_i_shtdwn, batt_low, alarm_req;
  logic [1:0]  fault_code;
  logic [4:0]  obs;
  int          total = 0;
  int          bad = 0;

  localparam logic [4:0] V_CLR  = 5'b0_0_0_00;
  localparam logic [4:0] V_OVR  = 5'b1_0_1_10;
  localparam logic [4:0] V_BATT = 5'b0_1_1_01;
  localparam logic [4:0] V_BOTH = 5'b1_1_1_11;

  always #5 clk = ~clk;

  assign obs = {ovr_i_shtdwn, batt_low, alarm_req, fault_code};

  fault_supervisor dut (
    .clk(clk), .rst(rst), .pwm_synch(pwm_synch), .OVR_I_lft(OVR_I_lft), .OVR_I_rght(OVR_I_rght),
    .batt(batt), .batt_vld(batt_vld), .pwr_up(pwr_up), .ovr_i_shtdwn(ovr_i_shtdwn),
    .batt_low(batt_low), .alarm_req(alarm_req), .fault_code(fault_code)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic vld, input logic [11:0] b);
    pwm_synch = 1'b1;
    batt_vld  = vld;
    if (vld) batt = b;
    @(negedge clk);
    pwm_synch = 1'b0;
    batt_vld  = 1'b0;
  endtask

  task automatic period();
    idle(P - 1);
    pulse(1'b0, batt);
  endtask

  task automatic sample(input logic [11:0] b);
    batt     = b;
    batt_vld = 1'b1;
    @(negedge clk);
    batt_vld = 1'b0;
    idle(10);
  endtask

  task automatic test_reset();
    rst = 1'b1; pwm_synch = 1'b0; OVR_I_lft = 1'b0; OVR_I_rght = 1'b0;
    batt = 12'hA00; batt_vld = 1'b0; pwr_up = 1'b1;
    idle(3);
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL reset_hold: got %b want %b", obs, V_CLR); end
    rst = 1'b0;
    idle(20);
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL reset_release: got %b want %b", obs, V_CLR); end
  endtask

  task automatic test_ovr_trip();
    pulse(1'b0, batt);
    OVR_I_rght = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      period();
      if (i == 15) begin
        total++;
        if (obs !== V_CLR) begin bad++; $display("FAIL trip_15: got %b want %b", obs, V_CLR); end
      end
    end
    total++;
    if (obs !== V_OVR) begin bad++; $display("FAIL trip_16: got %b want %b", obs, V_OVR); end
    OVR_I_rght = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      period();
      if (i == 7) begin
        total++;
        if (obs !== V_OVR) begin bad++; $display("FAIL recov_7: got %b want %b", obs, V_OVR); end
      end
    end
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL recov_8: got %b want %b", obs, V_CLR); end
  endtask

  task automatic test_blanking();
    int hits = 0;
    for (int i = 0; i < 20; i++) begin
      idle(10); OVR_I_lft = 1'b1;
      idle(140); OVR_I_lft = 1'b0;
      idle(P - 1 - 150);
      pulse(1'b0, batt);
      if (obs !== V_CLR) hits++;
    end
    total++;
    if (hits !== 0) begin bad++; $display("FAIL blank_ignored: got %0d set periods want 0", hits); end
    for (int i = 1; i <= 16; i++) begin
      idle(265); OVR_I_lft = 1'b1;
      idle(3); OVR_I_lft = 1'b0;
      idle(P - 1 - 268);
      pulse(1'b0, batt);
      if (i == 15) begin
        total++;
        if (obs !== V_CLR) begin bad++; $display("FAIL late_15: got %b want %b", obs, V_CLR); end
      end
    end
    total++;
    if (obs !== V_OVR) begin bad++; $display("FAIL late_16: got %b want %b", obs, V_OVR); end
    for (int i = 0; i < 8; i++) period();
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL late_recov: got %b want %b", obs, V_CLR); end
  endtask

  task automatic test_batt();
    sample(12'hA00);
    for (int i = 0; i < 3; i++) sample(12'h350);
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL batt_3: got %b want %b", obs, V_CLR); end
    batt = 12'h350; batt_vld = 1'b1;
    @(negedge clk);
    batt_vld = 1'b0;
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL batt_4_edge: got %b want %b", obs, V_CLR); end
    @(negedge clk);
    total++;
    if (obs !== V_BATT) begin bad++; $display("FAIL batt_4_set: got %b want %b", obs, V_BATT); end
    idle(10);
    sample(12'h820);
    total++;
    if (obs !== V_BATT) begin bad++; $display("FAIL band_820: got %b want %b", obs, V_BATT); end
    sample(12'h83F);
    total++;
    if (obs !== V_BATT) begin bad++; $display("FAIL band_83f: got %b want %b", obs, V_BATT); end
    sample(12'h840);
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL clear_840: got %b want %b", obs, V_CLR); end
    for (int i = 0; i < 3; i++) sample(12'h7FF);
    sample(12'h800);
    sample(12'h7FF);
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL filt_restart: got %b want %b", obs, V_CLR); end
    for (int i = 0; i < 3; i++) sample(12'h7FF);
    total++;
    if (obs !== V_BATT) begin bad++; $display("FAIL filt_7ff: got %b want %b", obs, V_BATT); end
    sample(12'h900);
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL clear_900: got %b want %b", obs, V_CLR); end
  endtask

  task automatic test_both();
    pulse(1'b0, batt);
    OVR_I_rght = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      idle(P - 1);
      pulse(i <= 4, 12'h350);
    end
    total++;
    if (obs !== V_BOTH) begin bad++; $display("FAIL both_set: got %b want %b", obs, V_BOTH); end
    OVR_I_rght = 1'b0;
    idle(P - 1);
    pulse(1'b1, 12'h900);
    total++;
    if (obs !== V_OVR) begin bad++; $display("FAIL both_batt_clr: got %b want %b", obs, V_OVR); end
    for (int i = 0; i < 7; i++) period();
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL both_clr: got %b want %b", obs, V_CLR); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) sample(12'h350);
    OVR_I_rght = 1'b1;
    period(); period();
    total++;
    if (obs !== V_BATT) begin bad++; $display("FAIL mid_pre: got %b want %b", obs, V_BATT); end
    rst = 1'b1; OVR_I_rght = 1'b0; batt = 12'hA00;
    #1;
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL mid_async: got %b want %b", obs, V_CLR); end
    idle(3);
    rst = 1'b0;
    pulse(1'b0, batt);
    OVR_I_rght = 1'b1;
    for (int i = 0; i < 15; i++) period();
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL mid_clean_cnt: got %b want %b", obs, V_CLR); end
    period();
    total++;
    if (obs !== V_OVR) begin bad++; $display("FAIL mid_retrip: got %b want %b", obs, V_OVR); end
  endtask

  task automatic test_pwr_up();
`ifdef FAULT_STICKY_EN
    int drops = 0;
    OVR_I_rght = 1'b0;
    for (int i = 0; i < 50; i++) begin
      period();
      if (obs !== V_OVR) drops++;
    end
    total++;
    if (drops !== 0) begin bad++; $display("FAIL sticky_hold: got %0d dropped periods want 0", drops); end
`endif
    pwr_up = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL pwr_drop: got %b want %b", obs, V_CLR); end
    OVR_I_rght = 1'b1;
    for (int i = 0; i < 20; i++) period();
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL pwr_hold: got %b want %b", obs, V_CLR); end
    pwr_up = 1'b1;
    OVR_I_rght = 1'b0;
    period(); period();
    total++;
    if (obs !== V_CLR) begin bad++; $display("FAIL pwr_restore: got %b want %b", obs, V_CLR); end
  endtask

  initial begin
    test_reset();
    test_ovr_trip();
    test_blanking();
    test_batt();
    test_both();
    test_reset_mid();
    test_pwr_up();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
